dht11_sample_sched: RTL and testbench
=====================================

DHT11_SAMPLE_SCHED -- requirements
Module: dht11_sample_sched

Interface
REQ-001 SHALL have parameter STARTUP_CYC, default 100_000_000, meaning cycles waited after reset before the first trigger is allowed.
REQ-002 SHALL have parameter EN_HIGH_CYC, default 4, meaning the width in cycles of each sample_en high pulse.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 5_000_000, meaning the maximum cycles waited for data_rdy after sample_en falls.
REQ-004 SHALL have parameter GAP_CYC, default 50_000_000, meaning the minimum cycles between the end of one transaction and the next trigger.
REQ-005 SHALL have parameter AUTO_IDLE_CYC, default 50_000_000, meaning the cycles spent in IDLE before an automatic trigger.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port auto_en, input, 1 bit: enables periodic sampling.
REQ-009 SHALL have port req, input, 1 bit: single-cycle on-demand sample request.
REQ-010 SHALL have port sample_en, output, 1 bit: conversion start to the sensor interface block.
REQ-011 SHALL have port data_rdy, input, 1 bit: conversion-complete strobe from the sensor interface block.
REQ-012 SHALL have ports temp_in and hum_in, input, 8 bits each: raw temperature and humidity from the sensor interface block.
REQ-013 SHALL have ports temp_out and hum_out, output, 8 bits each: the last successfully captured readings.
REQ-014 SHALL have ports valid (1b, sticky after the first capture), upd (1b, one-cycle pulse per capture), timeout_err (1b, one-cycle pulse per timeout), err_cnt (8b, saturating timeout count) and busy (1b, high in TRIG/WAIT/GAP).

Function
REQ-015 SHALL implement states INIT, IDLE, TRIG, WAIT and GAP, with a single shared cycle counter cnt cleared on every state entry.
REQ-016 INIT SHALL go to IDLE when cnt == STARTUP_CYC-1.
REQ-017 IDLE SHALL go to TRIG when pend is 1, or when auto_en is 1 and cnt == AUTO_IDLE_CYC-1.
REQ-018 IDLE SHALL hold cnt at 0 while auto_en is 0.
REQ-019 TRIG SHALL drive sample_en high for exactly EN_HIGH_CYC cycles, then go to WAIT; sample_en SHALL be registered and low in every other state.
REQ-020 WAIT SHALL sample data_rdy every cycle; when data_rdy is 1 it SHALL go to GAP, capturing temp_in/hum_in on that same edge.
REQ-021 On a capture, temp_out, hum_out, valid=1 and upd=1 SHALL all become visible one cycle after the data_rdy-high edge.
REQ-022 If WAIT reaches cnt == TIMEOUT_CYC-1 without data_rdy, the block SHALL go to GAP, pulse timeout_err for one cycle, increment err_cnt (saturating at 255) and leave temp_out/hum_out unchanged.
REQ-023 If data_rdy is 1 on the timeout cycle, it SHALL be treated as a capture and not as a timeout.
REQ-024 GAP SHALL go to IDLE when cnt == GAP_CYC-1.
REQ-025 A req seen in any state other than IDLE SHALL set a one-deep pend flag; further reqs while pend is 1 SHALL be dropped.
REQ-026 A req seen in IDLE SHALL cause a trigger on the next cycle.
REQ-027 pend SHALL clear on TRIG entry.
REQ-028 If req and an auto trigger coincide, exactly one TRIG SHALL result, and pend SHALL be 0 afterwards.
REQ-029 data_rdy outside WAIT SHALL be ignored.
REQ-030 Deasserting auto_en SHALL NOT abort a transaction in progress.

Reset
REQ-031 While rst_n is 0, the block SHALL be in INIT with cnt=0, pend=0, sample_en=0, temp_out=0, hum_out=0, valid=0, upd=0, timeout_err=0, err_cnt=0 and busy=0.
REQ-032 Reset asserted mid-transaction SHALL immediately force sample_en low and discard the transaction; after release, the block SHALL repeat the full STARTUP_CYC wait.

Verification (STARTUP_CYC=10, EN_HIGH_CYC=4, TIMEOUT_CYC=50, GAP_CYC=8, AUTO_IDLE_CYC=20)
REQ-033 Release rst_n with auto_en=1 -> sample_en rises 30 cycles after release, stays high 4 cycles; busy=1 from TRIG entry.
REQ-034 In WAIT, pulse data_rdy for one cycle with temp_in=0x19 and hum_in=0x3C -> next cycle temp_out=0x19, hum_out=0x3C, valid=1, upd=1 for one cycle; IDLE is re-entered 8 cycles later.
REQ-035 Never assert data_rdy -> timeout_err pulses 50 cycles after WAIT entry, err_cnt=1, outputs keep previous values; force 256 timeouts -> err_cnt stays at 255.
REQ-036 auto_en=0, req pulsed in IDLE -> TRIG one cycle later; two reqs pulsed during WAIT -> exactly one extra TRIG after GAP.
REQ-037 Assert rst_n=0 during TRIG -> sample_en=0 asynchronously, all outputs take their reset values; after release, no trigger occurs before 10 cycles.

Source files
------------

// File: rtl/dht11_sample_sched.sv
// Sample scheduler for a DHT11 sensor front end: paces conversion requests
// (periodic or on demand), waits for completion with a timeout, and holds the last good reading.
module dht11_sample_sched #(
    parameter int STARTUP_CYC   = 100_000_000,
    parameter int EN_HIGH_CYC   = 4,
    parameter int TIMEOUT_CYC   = 5_000_000,
    parameter int GAP_CYC       = 50_000_000,
    parameter int AUTO_IDLE_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       auto_en,
    input  logic       req,
    output logic       sample_en,
    input  logic       data_rdy,
    input  logic [7:0] temp_in,
    input  logic [7:0] hum_in,
    output logic [7:0] temp_out,
    output logic [7:0] hum_out,
    output logic       valid,
    output logic       upd,
    output logic       timeout_err,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST      = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST      = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] AUTO_LAST    = CNT_W'(AUTO_IDLE_CYC - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_TRIG, S_WAIT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             sample_en_q, sample_en_d;
    logic [7:0]       temp_q, temp_d;
    logic [7:0]       hum_q, hum_d;
    logic             valid_q, valid_d;
    logic             upd_q, upd_d;
    logic             timeout_err_q, timeout_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             capture;
    logic             timeout;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_INIT: if (cnt_q == STARTUP_LAST) state_d = S_IDLE;
            S_IDLE: if (pend_q || req || (auto_en && cnt_q == AUTO_LAST)) state_d = S_TRIG;
            S_TRIG: if (cnt_q == EN_LAST) state_d = S_WAIT;
            S_WAIT: begin
                // A completion strobe on the last allowed cycle still counts as a capture.
                if (data_rdy) begin
                    capture = 1'b1;
                    state_d = S_GAP;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP:  if (cnt_q == GAP_LAST) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        // The shared counter restarts on every state change; IDLE freezes it while periodic mode is off.
        if (state_d != state_q || (state_q == S_IDLE && !auto_en)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (state_d == S_TRIG && state_q != S_TRIG) begin
            pend_d = 1'b0;
        end else if (req && state_q != S_IDLE) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        sample_en_d   = (state_d == S_TRIG);
        temp_d        = capture ? temp_in : temp_q;
        hum_d         = capture ? hum_in : hum_q;
        valid_d       = valid_q | capture;
        upd_d         = capture;
        timeout_err_d = timeout;
        err_cnt_d     = (timeout && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            sample_en_q   <= 1'b0;
            temp_q        <= 8'd0;
            hum_q         <= 8'd0;
            valid_q       <= 1'b0;
            upd_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            sample_en_q   <= sample_en_d;
            temp_q        <= temp_d;
            hum_q         <= hum_d;
            valid_q       <= valid_d;
            upd_q         <= upd_d;
            timeout_err_q <= timeout_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign sample_en   = sample_en_q;
    assign temp_out    = temp_q;
    assign hum_out     = hum_q;
    assign valid       = valid_q;
    assign upd         = upd_q;
    assign timeout_err = timeout_err_q;
    assign err_cnt     = err_cnt_q;
    assign busy        = (state_q == S_TRIG) || (state_q == S_WAIT) || (state_q == S_GAP);

endmodule

// File: tb/tb_dht11_sample_sched.sv
// Scoreboard bench for dht11_sample_sched: stimulus queues expected trigger, capture
// and timeout events; a monitor pops and compares them as the DUT produces them.
module tb_dht11_sample_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       auto_en;
    logic       req;
    logic       sample_en;
    logic       data_rdy;
    logic [7:0] temp_in;
    logic [7:0] hum_in;
    logic [7:0] temp_out;
    logic [7:0] hum_out;
    logic       valid;
    logic       upd;
    logic       timeout_err;
    logic [7:0] err_cnt;
    logic       busy;

    dht11_sample_sched #(
        .STARTUP_CYC  (10),
        .EN_HIGH_CYC  (4),
        .TIMEOUT_CYC  (50),
        .GAP_CYC      (8),
        .AUTO_IDLE_CYC(20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .auto_en    (auto_en),
        .req        (req),
        .sample_en  (sample_en),
        .data_rdy   (data_rdy),
        .temp_in    (temp_in),
        .hum_in     (hum_in),
        .temp_out   (temp_out),
        .hum_out    (hum_out),
        .valid      (valid),
        .upd        (upd),
        .timeout_err(timeout_err),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int t; int h; } cap_t;
    typedef struct { int cyc; int e; } to_t;

    int   q_trig[$];
    cap_t q_cap[$];
    to_t  q_to[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every negedge, match DUT events against the expectation queues.
    logic se_prev = 1'b0;
    int   se_hi   = 0;
    always @(negedge clk) begin
        if (sample_en && !se_prev) begin
            if (q_trig.size() == 0) chk("unexpected_trigger", cyc, -1);
            else chk("trigger_cycle", cyc, q_trig.pop_front());
        end
        if (upd) begin
            if (q_cap.size() == 0) chk("unexpected_capture", cyc, -1);
            else begin
                cap_t c;
                c = q_cap.pop_front();
                chk("capture_cycle", cyc, c.cyc);
                chk("capture_temp", int'(temp_out), c.t);
                chk("capture_hum", int'(hum_out), c.h);
                chk("capture_valid", int'(valid), 1);
            end
        end
        if (timeout_err) begin
            if (q_to.size() == 0) chk("unexpected_timeout", cyc, -1);
            else begin
                to_t t;
                t = q_to.pop_front();
                chk("timeout_cycle", cyc, t.cyc);
                chk("timeout_err_cnt", int'(err_cnt), t.e);
            end
        end
        if (!rst_n) se_hi = 0;
        else if (sample_en) se_hi++;
        else if (se_prev) begin
            chk("sample_en_width", se_hi, 4);
            se_hi = 0;
        end
        se_prev = sample_en;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int r2;
        int c;
        int e;

        rst_n = 1'b0; auto_en = 1'b1; req = 1'b0; data_rdy = 1'b0;
        temp_in = 8'h00; hum_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sample_en", int'(sample_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_temp_out", int'(temp_out), 0);

        // Power-up with periodic sampling, then one good capture.
        rst_n = 1'b1;
        r = cyc;
        q_trig.push_back(r + 30);
        wait_until(r + 29);
        chk("busy_before_trig", int'(busy), 0);
        wait_until(r + 30);
        chk("busy_at_trig", int'(busy), 1);
        wait_until(r + 36);
        data_rdy = 1'b1; temp_in = 8'h19; hum_in = 8'h3C;
        q_cap.push_back('{r + 37, 'h19, 'h3C});
        @(negedge clk);
        data_rdy = 1'b0; temp_in = 8'h77; hum_in = 8'h88;
        wait_until(r + 40);
        data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
        wait_until(r + 44);
        chk("busy_in_gap", int'(busy), 1);
        wait_until(r + 45);
        chk("busy_idle_after_gap", int'(busy), 0);

        // Next automatic trigger times out; auto_en drops mid-transaction.
        q_trig.push_back(r + 65);
        q_to.push_back('{r + 119, 1});
        wait_until(r + 80);
        auto_en = 1'b0;
        wait_until(r + 121);
        chk("to_keeps_temp", int'(temp_out), 'h19);
        chk("to_keeps_hum", int'(hum_out), 'h3C);
        chk("to_keeps_valid", int'(valid), 1);

        // On-demand request in IDLE, then two requests during WAIT collapse to one.
        wait_until(r + 135);
        req = 1'b1;
        q_trig.push_back(r + 136);
        @(negedge clk);
        req = 1'b0;
        wait_until(r + 142);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_until(r + 145);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_until(r + 150);
        data_rdy = 1'b1; temp_in = 8'hA5; hum_in = 8'h5A;
        q_cap.push_back('{r + 151, 'hA5, 'h5A});
        q_trig.push_back(r + 160);
        q_to.push_back('{r + 214, 2});
        @(negedge clk);
        data_rdy = 1'b0;
        wait_until(r + 240);
        chk("idle_after_pend", int'(busy), 0);

        // Request coincides with the automatic trigger: only one transaction.
        auto_en = 1'b1;
        wait_until(r + 259);
        req = 1'b1;
        q_trig.push_back(r + 260);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        auto_en = 1'b0;
        wait_until(r + 265);
        data_rdy = 1'b1; temp_in = 8'h00; hum_in = 8'hFF;
        q_cap.push_back('{r + 266, 'h00, 'hFF});
        @(negedge clk);
        data_rdy = 1'b0;
        wait_until(r + 290);
        chk("idle_after_coincide", int'(busy), 0);
        chk("hum_after_coincide", int'(hum_out), 'hFF);

        // Reset during TRIG, then a request issued during the startup wait.
        req = 1'b1;
        q_trig.push_back(r + 291);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sample_en", int'(sample_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_temp", int'(temp_out), 0);
        chk("midrst_hum", int'(hum_out), 0);
        chk("midrst_upd", int'(upd), 0);
        chk("midrst_timeout_err", int'(timeout_err), 0);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req = 1'b1;
        r2 = cyc;
        q_trig.push_back(r2 + 11);
        q_to.push_back('{r2 + 65, 1});
        @(negedge clk);
        req = 1'b0;
        wait_until(r2 + 10);
        chk("no_trig_during_startup", int'(busy), 0);

        // Repeated timeouts until the error counter saturates.
        c = r2 + 75;
        e = 1;
        wait_until(c);
        for (int i = 0; i < 258; i++) begin
            req = 1'b1;
            temp_in = 8'($urandom);
            hum_in = 8'($urandom);
            e = (e < 255) ? e + 1 : 255;
            q_trig.push_back(c + 1);
            q_to.push_back('{c + 55, e});
            @(negedge clk);
            req = 1'b0;
            c = c + 64;
            wait_until(c);
        end
        chk("err_cnt_saturated", int'(err_cnt), 255);
        chk("sat_temp_unchanged", int'(temp_out), 0);
        chk("sat_valid_unchanged", int'(valid), 0);

        wait_until(c + 10);
        chk("pending_triggers", q_trig.size(), 0);
        chk("pending_captures", q_cap.size(), 0);
        chk("pending_timeouts", q_to.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
